// File: rtl/image_sram_arbiter.sv
// Image-SRAM port arbiter: shares one SRAM port between the MCU stream path and
// the dithering engine. Round-robin between the two, with a per-requester lock so a
// read-modify-write sequence stays atomic. Read returns are tagged and routed back to
// the requester that issued them.
module image_sram_arbiter #(
    parameter int unsigned IMAGE_ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH       = 24,
    parameter int unsigned RD_LATENCY       = 2,
    parameter int unsigned LOCK_MAX         = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mcu_req,
    input  logic                        mcu_we,
    input  logic                        mcu_lock,
    input  logic [IMAGE_ADDR_WIDTH-1:0] mcu_addr,
    input  logic [DATA_WIDTH-1:0]       mcu_wdata,
    output logic                        mcu_gnt,
    output logic                        mcu_rvalid,
    input  logic                        dith_req,
    input  logic                        dith_we,
    input  logic                        dith_lock,
    input  logic [IMAGE_ADDR_WIDTH-1:0] dith_addr,
    input  logic [DATA_WIDTH-1:0]       dith_wdata,
    output logic                        dith_gnt,
    output logic                        dith_rvalid,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic [IMAGE_ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]       sram_wdata,
    output logic                        sram_rden,
    output logic                        sram_wren,
    input  logic [DATA_WIDTH-1:0]       sram_rdata,
    output logic                        lock_err
);

    localparam int unsigned CntWidth = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN_MCU,
        OWN_DITH
    } state_t;

    state_t                state;
    state_t                issue_state;
    logic                  last_dith;    // 1: dither engine was granted most recently
    logic [CntWidth-1:0]   lock_cnt;
    logic                  ign_mcu;      // lock ignored after a forced release
    logic                  ign_dith;
    logic [RD_LATENCY-1:0] tag_vld;
    logic [RD_LATENCY-1:0] tag_dith;

    logic arb_mcu;
    logic arb_dith;
    logic gnt_m;
    logic gnt_d;
    logic rd_issue;

    // Grant decision: owner has absolute priority while it requests or holds its lock;
    // otherwise plain round-robin with the tie going to the side not granted last.
    always_comb begin
        arb_mcu  = mcu_req & (~dith_req | last_dith);
        arb_dith = dith_req & (~mcu_req | ~last_dith);
        gnt_m    = 1'b0;
        gnt_d    = 1'b0;
        unique case (state)
            OWN_MCU: begin
                if (mcu_req || mcu_lock) begin
                    gnt_m = mcu_req;
                end else begin
                    gnt_d = arb_dith;
                end
            end
            OWN_DITH: begin
                if (dith_req || dith_lock) begin
                    gnt_d = dith_req;
                end else begin
                    gnt_m = arb_mcu;
                end
            end
            default: begin
                gnt_m = arb_mcu;
                gnt_d = arb_dith;
            end
        endcase
        gnt_m    = gnt_m & rst_n;
        gnt_d    = gnt_d & rst_n;
        rd_issue = (gnt_m & ~mcu_we) | (gnt_d & ~dith_we);
    end

    // SRAM port mux and read-data forwarding; everything is quiet while in reset.
    always_comb begin
        mcu_gnt    = gnt_m;
        dith_gnt   = gnt_d;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_rden  = 1'b0;
        sram_wren  = 1'b0;
        if (gnt_m) begin
            sram_addr  = mcu_addr;
            sram_wdata = mcu_wdata;
            sram_wren  = mcu_we;
            sram_rden  = ~mcu_we;
        end else if (gnt_d) begin
            sram_addr  = dith_addr;
            sram_wdata = dith_wdata;
            sram_wren  = dith_we;
            sram_rden  = ~dith_we;
        end
        rdata       = rst_n ? sram_rdata : '0;
        mcu_rvalid  = tag_vld[RD_LATENCY-1] & ~tag_dith[RD_LATENCY-1];
        dith_rvalid = tag_vld[RD_LATENCY-1] & tag_dith[RD_LATENCY-1];
    end

    // State that follows from this cycle's issue when no lock is being held.
    always_comb begin
        if (gnt_m && mcu_lock && !ign_mcu) begin
            issue_state = OWN_MCU;
        end else if (gnt_d && dith_lock && !ign_dith) begin
            issue_state = OWN_DITH;
        end else begin
            issue_state = IDLE;
        end
    end

    // Ownership FSM with lock timeout, round-robin history and sticky lock error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_dith <= 1'b1;
            lock_cnt  <= '0;
            ign_mcu   <= 1'b0;
            ign_dith  <= 1'b0;
            lock_err  <= 1'b0;
        end else begin
            if (gnt_m) begin
                last_dith <= 1'b0;
            end else if (gnt_d) begin
                last_dith <= 1'b1;
            end
            ign_mcu  <= ign_mcu & mcu_lock;
            ign_dith <= ign_dith & dith_lock;
            unique case (state)
                OWN_MCU: begin
                    if (mcu_lock) begin
                        if (lock_cnt == CntWidth'(LOCK_MAX - 1)) begin
                            state    <= IDLE;
                            lock_cnt <= '0;
                            lock_err <= 1'b1;
                            ign_mcu  <= 1'b1;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end else begin
                        state    <= issue_state;
                        lock_cnt <= '0;
                    end
                end
                OWN_DITH: begin
                    if (dith_lock) begin
                        if (lock_cnt == CntWidth'(LOCK_MAX - 1)) begin
                            state    <= IDLE;
                            lock_cnt <= '0;
                            lock_err <= 1'b1;
                            ign_dith <= 1'b1;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end else begin
                        state    <= issue_state;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= issue_state;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    // Read tag pipe: {valid, owner} shifts along with the SRAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld  <= '0;
            tag_dith <= '0;
        end else begin
            tag_vld[0]  <= rd_issue;
            tag_dith[0] <= gnt_d;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_dith[i] <= tag_dith[i-1];
            end
        end
    end

endmodule
